// File: rtl/bomb_array.sv
// Bomb slot array: placement arbitration, fuse timers, chain detonation, explosion output register, sprite hit test.
// Explosion records leave through a one-entry valid/ready register; pixel lookup has one cycle of latency.
module bomb_array #(
  parameter int NUM_BOMBS   = 6,
  parameter int COORD_W     = 10,
  parameter int FUSE_CYCLES = 400000000,
  parameter int TILE_W      = 16,
  parameter int TILE_H      = 16,
  localparam int CNT_W  = $clog2(NUM_BOMBS + 1),
  localparam int FUSE_W = $clog2(FUSE_CYCLES),
  localparam int ROW_W  = $clog2(TILE_H),
  localparam int COL_W  = $clog2(TILE_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               place_btn,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [CNT_W-1:0]   max_bombs,
  input  logic               chain_valid,
  input  logic [COORD_W-1:0] chain_x,
  input  logic [COORD_W-1:0] chain_y,
  input  logic [COORD_W-1:0] v_x,
  input  logic [COORD_W-1:0] v_y,
  output logic               place_ack,
  output logic               place_reject,
  output logic [CNT_W-1:0]   active_count,
  output logic               expl_valid,
  input  logic               expl_ready,
  output logic [COORD_W-1:0] expl_x,
  output logic [COORD_W-1:0] expl_y,
  output logic               pix_on,
  output logic [ROW_W-1:0]   pix_row,
  output logic [COL_W-1:0]   pix_col
);

  localparam int IDX_W = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam logic [COORD_W:0] X_SPAN = (COORD_W+1)'(TILE_W - 1);
  localparam logic [COORD_W:0] Y_SPAN = (COORD_W+1)'(TILE_H - 1);
  localparam logic [FUSE_W-1:0] FUSE_LAST = FUSE_W'(FUSE_CYCLES - 1);

  typedef enum logic [1:0] {S_FREE, S_ARMED, S_PENDING} slot_st_t;

  slot_st_t           st_q   [NUM_BOMBS];
  slot_st_t           st_d   [NUM_BOMBS];
  logic [FUSE_W-1:0]  fuse_q [NUM_BOMBS];
  logic [FUSE_W-1:0]  fuse_d [NUM_BOMBS];
  logic [COORD_W-1:0] x_q    [NUM_BOMBS];
  logic [COORD_W-1:0] y_q    [NUM_BOMBS];

  logic btn_prev, req, accept, free_found, dup, pend_found, out_free, pop;
  logic [IDX_W-1:0] free_idx, pend_idx;
  logic [CNT_W-1:0] count_d;
  logic hit;
  logic [COORD_W-1:0] dx, dy;

  // Slot scan: lowest FREE slot, lowest PENDING slot, duplicate-tile detection.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    dup        = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (st_q[i] == S_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (st_q[i] == S_PENDING && !pend_found) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
      if (st_q[i] != S_FREE && x_q[i] == b_x && y_q[i] == b_y)
        dup = 1'b1;
    end
    req      = place_btn & ~btn_prev;
    accept   = req & free_found & ~dup & (active_count < max_bombs);
    out_free = ~expl_valid | expl_ready;
    pop      = out_free & pend_found;
  end

  // Next slot state; arming, expiry/chain and freeing touch disjoint states.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      st_d[i]   = st_q[i];
      fuse_d[i] = fuse_q[i];
      case (st_q[i])
        S_FREE: begin
          if (accept && free_idx == IDX_W'(i)) begin
            st_d[i]   = S_ARMED;
            fuse_d[i] = '0;
          end
        end
        S_ARMED: begin
          if (fuse_q[i] == FUSE_LAST ||
              (chain_valid && chain_x == x_q[i] && chain_y == y_q[i]))
            st_d[i] = S_PENDING;
          else
            fuse_d[i] = fuse_q[i] + FUSE_W'(1);
        end
        S_PENDING: begin
          if (pop && pend_idx == IDX_W'(i))
            st_d[i] = S_FREE;
        end
        default: st_d[i] = S_FREE;
      endcase
      if (st_d[i] != S_FREE)
        count_d = count_d + CNT_W'(1);
    end
  end

  // Sprite hit test at COORD_W+1 bits so a tile at the coordinate edge does not wrap.
  always_comb begin
    hit = 1'b0;
    dx  = '0;
    dy  = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!hit && st_q[i] == S_ARMED &&
          {1'b0, v_x} >= {1'b0, x_q[i]} && {1'b0, v_x} <= {1'b0, x_q[i]} + X_SPAN &&
          {1'b0, v_y} >= {1'b0, y_q[i]} && {1'b0, v_y} <= {1'b0, y_q[i]} + Y_SPAN) begin
        hit = 1'b1;
        dx  = v_x - x_q[i];
        dy  = v_y - y_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        st_q[i]   <= S_FREE;
        fuse_q[i] <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
      end
      btn_prev     <= 1'b1;
      place_ack    <= 1'b0;
      place_reject <= 1'b0;
      active_count <= '0;
      expl_valid   <= 1'b0;
      expl_x       <= '0;
      expl_y       <= '0;
      pix_on       <= 1'b0;
      pix_row      <= '0;
      pix_col      <= '0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        st_q[i]   <= st_d[i];
        fuse_q[i] <= fuse_d[i];
      end
      if (accept) begin
        x_q[free_idx] <= b_x;
        y_q[free_idx] <= b_y;
      end
      btn_prev     <= place_btn;
      place_ack    <= accept;
      place_reject <= req & ~accept;
      active_count <= count_d;
      if (out_free) begin
        expl_valid <= pend_found;
        if (pend_found) begin
          expl_x <= x_q[pend_idx];
          expl_y <= y_q[pend_idx];
        end
      end
      pix_on  <= hit;
      pix_row <= dy[ROW_W-1:0];
      pix_col <= dx[COL_W-1:0];
    end
  end

endmodule

// File: tb/tb_bomb_array.sv
// Directed bench for bomb_array: 2 slots, 8-cycle fuse, 16x16 sprites.
module tb_bomb_array;

  logic       clk, reset, place_btn, chain_valid, expl_ready;
  logic [9:0] b_x, b_y, chain_x, chain_y, v_x, v_y;
  logic [1:0] max_bombs;
  logic       place_ack, place_reject, expl_valid, pix_on;
  logic [1:0] active_count;
  logic [9:0] expl_x, expl_y;
  logic [3:0] pix_row, pix_col;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;

  bomb_array #(
    .NUM_BOMBS(2), .COORD_W(10), .FUSE_CYCLES(8), .TILE_W(16), .TILE_H(16)
  ) dut (
    .clk(clk), .reset(reset), .place_btn(place_btn), .b_x(b_x), .b_y(b_y),
    .max_bombs(max_bombs), .chain_valid(chain_valid), .chain_x(chain_x), .chain_y(chain_y),
    .v_x(v_x), .v_y(v_y), .place_ack(place_ack), .place_reject(place_reject),
    .active_count(active_count), .expl_valid(expl_valid), .expl_ready(expl_ready),
    .expl_x(expl_x), .expl_y(expl_y), .pix_on(pix_on), .pix_row(pix_row), .pix_col(pix_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Button goes high for one sample; the request is registered at the next edge.
  task automatic press(input logic [9:0] x, input logic [9:0] y);
    b_x = x;
    b_y = y;
    place_btn = 1'b1;
    tick();
    place_btn = 1'b0;
  endtask

  task automatic drain(input string tag);
    n = 0;
    while ((active_count != 0 || expl_valid) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, (n < 40), 1);
  endtask

  initial begin
    reset = 1'b0; place_btn = 1'b0; chain_valid = 1'b0; expl_ready = 1'b1;
    b_x = '0; b_y = '0; chain_x = '0; chain_y = '0; v_x = '0; v_y = '0;
    max_bombs = 2'd2;
    tick();
    tick();
    chk("rst_ack", place_ack, 0);
    chk("rst_count", active_count, 0);
    chk("rst_expl_valid", expl_valid, 0);
    chk("rst_pix_on", pix_on, 0);
    reset = 1'b1;
    tick();

    // Single bomb: expiry at the 8th edge after arming, record registered on the 9th.
    press(10'd32, 10'd48);
    chk("p1_ack", place_ack, 1);
    chk("p1_reject", place_reject, 0);
    chk("p1_count", active_count, 1);
    n = 0;
    while (!expl_valid && n < 20) begin
      tick();
      n++;
    end
    chk("fuse_latency", n, 9);
    chk("p1_expl_x", expl_x, 32);
    chk("p1_expl_y", expl_y, 48);
    chk("p1_count_after", active_count, 0);
    tick();
    chk("p1_expl_drop", expl_valid, 0);

    // Duplicate tile and bomb cap.
    press(10'd32, 10'd48);
    chk("p2_ack", place_ack, 1);
    tick();
    press(10'd32, 10'd48);
    chk("dup_reject", place_reject, 1);
    chk("dup_no_ack", place_ack, 0);
    chk("dup_count", active_count, 1);
    tick();
    press(10'd80, 10'd48);
    chk("p3_ack", place_ack, 1);
    chk("p3_count", active_count, 2);
    tick();
    press(10'd96, 10'd48);
    chk("cap_reject", place_reject, 1);
    chk("cap_count", active_count, 2);
    drain("drain1_timeout");

    // Backpressure: two expired bombs wait behind a stalled consumer.
    expl_ready = 1'b0;
    press(10'd16, 10'd16);
    chk("bp0_ack", place_ack, 1);
    tick();
    press(10'd48, 10'd16);
    chk("bp1_ack", place_ack, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 8 && !(expl_valid && expl_x == 16 && expl_y == 16)) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_valid", expl_valid, 1);
    chk("bp_count", active_count, 1);
    expl_ready = 1'b1;
    tick();
    chk("bp_second_valid", expl_valid, 1);
    chk("bp_second_x", expl_x, 48);
    chk("bp_second_y", expl_y, 16);
    chk("bp_count_zero", active_count, 0);
    tick();
    chk("bp_empty", expl_valid, 0);

    // Chain detonation long before the fuse runs out.
    press(10'd64, 10'd64);
    chk("ch_ack", place_ack, 1);
    tick();
    tick();
    chain_valid = 1'b1; chain_x = 10'd64; chain_y = 10'd64;
    tick();
    chain_valid = 1'b0;
    tick();
    chk("ch_valid", expl_valid, 1);
    chk("ch_x", expl_x, 64);
    chk("ch_y", expl_y, 64);
    tick();
    chk("ch_count", active_count, 0);

    // Chain at an empty tile leaves the armed bomb alone.
    press(10'd64, 10'd64);
    tick();
    chain_valid = 1'b1; chain_x = 10'd200; chain_y = 10'd200;
    tick();
    chain_valid = 1'b0;
    tick();
    chk("ch_miss_valid", expl_valid, 0);
    chk("ch_miss_count", active_count, 1);
    drain("drain2_timeout");

    // Sprite hit test.
    press(10'd100, 10'd200);
    v_x = 10'd103; v_y = 10'd209;
    tick();
    chk("pix_in_on", pix_on, 1);
    chk("pix_in_col", pix_col, 3);
    chk("pix_in_row", pix_row, 9);
    v_x = 10'd116; v_y = 10'd200;
    tick();
    chk("pix_right_off", pix_on, 0);
    chk("pix_off_col", pix_col, 0);
    v_x = 10'd115; v_y = 10'd215;
    tick();
    chk("pix_corner_on", pix_on, 1);
    chk("pix_corner_col", pix_col, 15);
    chk("pix_corner_row", pix_row, 15);
    v_x = 10'd99; v_y = 10'd200;
    tick();
    chk("pix_left_off", pix_on, 0);
    v_x = '0; v_y = '0;
    drain("drain3_timeout");
    press(10'd1016, 10'd1016);
    v_x = 10'd1023; v_y = 10'd1023;
    tick();
    chk("pix_edge_on", pix_on, 1);
    chk("pix_edge_col", pix_col, 7);
    chk("pix_edge_row", pix_row, 7);
    v_x = '0; v_y = '0;
    drain("drain4_timeout");

    // Reset mid-fuse with the button held.
    press(10'd32, 10'd32);
    tick();
    tick();
    place_btn = 1'b1;
    b_x = 10'd200; b_y = 10'd200;
    reset = 1'b0;
    tick();
    chk("mid_rst_count", active_count, 0);
    chk("mid_rst_ack", place_ack, 0);
    chk("mid_rst_expl", expl_valid, 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (place_ack || place_reject || active_count != 0 || expl_valid) bad++;
    end
    chk("held_btn_no_place", bad, 0);
    place_btn = 1'b0;
    tick();
    press(10'd40, 10'd40);
    chk("repress_ack", place_ack, 1);
    chk("repress_count", active_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
